// File: rtl/cpu_state_sequencer.sv
// Purpose : instruction-cycle sequencer for the multicycle MIPS core; emits the
//           state code (0=HALT 1=FETCH 2=DECODE 3=EXEC1 4=EXEC2) to control_unit.
// Latency : all outputs registered; ALU/LW instruction = 4 cycles, MULT/DIV = 4+MULDIV_CYCLES.
// Backpressure: Avalon waitrequest holds FETCH, EXEC1 (reads only) and EXEC2.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset (overrides everything)
//   waitrequest        Avalon stall from memory
//   memread, memwrite  strobes from control_unit (memwrite is informational only)
//   opcode, fun        instr[31:26] / instr[5:0] from the instruction register
//   halt_req           PC being written this cycle is zero
//   state              registered state code
//   active             high while the core is executing (low in HALT)
//   instr_count        retired instructions since reset, wraps
module cpu_state_sequencer #(
  parameter int MULDIV_CYCLES = 4,
  parameter int COUNT_WIDTH   = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   waitrequest,
  input  logic                   memread,
  input  logic                   memwrite,
  input  logic [5:0]             opcode,
  input  logic [5:0]             fun,
  input  logic                   halt_req,
  output logic [3:0]             state,
  output logic                   active,
  output logic [COUNT_WIDTH-1:0] instr_count
);

  localparam int CW = $clog2(MULDIV_CYCLES + 1);

  typedef enum logic [3:0] {
    ST_HALT   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_EXEC1  = 4'd3,
    ST_EXEC2  = 4'd4
  } state_t;

  // The state register is a raw 4-bit vector rather than state_t so that it can
  // legitimately hold the undefined codes 5..15 (upset or bad init) and recover.
  logic [3:0]             state_q, state_d;
  logic                   active_q, active_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [CW-1:0]          muldiv_cnt_q, muldiv_cnt_d;
  logic                   is_muldiv;

  // memwrite does not influence sequencing: waitrequest alone decides stalls.
  logic unused_memwrite;
  assign unused_memwrite = memwrite;

  // MULT/MULTU/DIV/DIVU are SPECIAL opcodes with fun = 0110xx.
  assign is_muldiv = (opcode == 6'b000000) && (fun[5:2] == 4'b0110);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    muldiv_cnt_d = muldiv_cnt_q;
    case (state_q)
      ST_FETCH: begin
        if (!waitrequest) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        state_d      = ST_EXEC1;
        muldiv_cnt_d = is_muldiv ? CW'(MULDIV_CYCLES) : '0;
      end
      ST_EXEC1: begin
        // The multi-cycle hold has priority; a read stall only matters once
        // the counter has drained.
        if (muldiv_cnt_q != '0) begin
          muldiv_cnt_d = muldiv_cnt_q - CW'(1);
        end else if (!(memread && waitrequest)) begin
          state_d = ST_EXEC2;
        end
      end
      ST_EXEC2: begin
        // Retire only when the PC write actually happens (waitrequest low);
        // halt_req is only meaningful on that cycle.
        if (!waitrequest) begin
          count_d = count_q + COUNT_WIDTH'(1);
          state_d = halt_req ? ST_HALT : ST_FETCH;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
    active_d = (state_d != ST_HALT);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_FETCH;
      active_q     <= 1'b1;
      count_q      <= '0;
      muldiv_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      active_q     <= active_d;
      count_q      <= count_d;
      muldiv_cnt_q <= muldiv_cnt_d;
    end
  end

  assign state       = state_q;
  assign active      = active_q;
  assign instr_count = count_q;

endmodule
